// File: rtl/spi_reg_pkg.sv
// Shared constants and types for the SPI write-only register bank:
// register addresses, register count and the transaction phase enum.
package spi_reg_pkg;

    localparam int NUM_REGS      = 5;

    localparam int ADDR_LOAD_CNT = 0;
    localparam int ADDR_TCM      = 1;
    localparam int ADDR_INSTR    = 2;
    localparam int ADDR_MODE     = 3;
    localparam int ADDR_SELECT   = 4;

    // The first byte after reset is an address; every later byte is data.
    typedef enum logic {
        PH_ADDR = 1'b0,
        PH_DATA = 1'b1
    } phase_t;

endpackage

// File: rtl/spi_deserializer.sv
// MSB-first serial-to-byte converter clocked by sclk.
// A byte completes on the 8th rising edge; byte_valid/byte_data are
// combinational so the consumer acts on the completed byte in that same edge.
// Optional macro SPI_SERIAL_OUT_EN exposes the bit counter for readback timing.
module spi_deserializer (
    input  logic       sclk,
    input  logic       rst,
    input  logic       serial_in,
    output logic       byte_valid,
    output logic [7:0] byte_data
`ifdef SPI_SERIAL_OUT_EN
    ,
    output logic [2:0] bit_cnt
`endif
);

    logic [6:0] shift;
    logic [2:0] cnt;

    // Shift in one bit per rising edge; the 3-bit counter wraps 7->0 on byte completion.
    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            shift <= 7'd0;
            cnt   <= 3'd0;
        end else begin
            shift <= {shift[5:0], serial_in};
            cnt   <= cnt + 3'd1;
        end
    end

    // The incoming bit completes the byte when seven bits are already held.
    assign byte_valid = (cnt == 3'd7);
    assign byte_data  = {shift, serial_in};

`ifdef SPI_SERIAL_OUT_EN
    assign bit_cnt = cnt;
`endif

endmodule

// File: rtl/spi_reg_bank.sv
// Write-only SPI slave register bank.
// First byte after reset sets the address pointer; each later byte writes the
// addressed register and the pointer auto-increments (mod 2^ADDR_W).
// Unmapped addresses drop writes. Only rst returns to the address phase.
// Optional macro SPI_SERIAL_OUT_EN adds serial_out, which replays the addressed
// register's previous contents MSB first on falling sclk edges during each data byte.
module spi_reg_bank
    import spi_reg_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic       sclk,
    input  logic       rst,
    input  logic       serial_in,
    output logic [7:0] load_cnt_ser,
    output logic [7:0] trigger_channel_mask,
    output logic [7:0] instruction,
    output logic [7:0] mode,
    output logic [2:0] select_reg
`ifdef SPI_SERIAL_OUT_EN
    ,
    output logic       serial_out
`endif
);

    logic              byte_valid;
    logic [7:0]        byte_data;
    phase_t            phase;
    phase_t            phase_next;
    logic [ADDR_W-1:0] ptr;
    logic              wr_en;

`ifdef SPI_SERIAL_OUT_EN
    logic [2:0]        bit_cnt;
`endif

    spi_deserializer u_deser (
        .sclk       (sclk),
        .rst        (rst),
        .serial_in  (serial_in),
        .byte_valid (byte_valid),
        .byte_data  (byte_data)
`ifdef SPI_SERIAL_OUT_EN
        ,
        .bit_cnt    (bit_cnt)
`endif
    );

    // Phase state register.
    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            phase <= PH_ADDR;
        end else begin
            phase <= phase_next;
        end
    end

    // Next phase: leave ADDR after the first byte, then stay in DATA until reset.
    always_comb begin
        phase_next = phase;
        case (phase)
            PH_ADDR: begin
                if (byte_valid) begin
                    phase_next = PH_DATA;
                end else begin
                    phase_next = PH_ADDR;
                end
            end
            PH_DATA: phase_next = PH_DATA;
            default: phase_next = PH_ADDR;
        endcase
    end

    assign wr_en = byte_valid && (phase == PH_DATA) && (ptr < ADDR_W'(NUM_REGS));

    // Address pointer: loaded by the address byte, incremented after every data byte.
    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (byte_valid) begin
            if (phase == PH_ADDR) begin
                ptr <= ADDR_W'(byte_data);
            end else begin
                ptr <= ptr + ADDR_W'(1);
            end
        end
    end

    // Register file: only the addressed mapped register takes the completed byte.
    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            load_cnt_ser         <= 8'd0;
            trigger_channel_mask <= 8'd0;
            instruction          <= 8'd0;
            mode                 <= 8'd0;
            select_reg           <= 3'd0;
        end else if (wr_en) begin
            case (ptr)
                ADDR_W'(ADDR_LOAD_CNT): load_cnt_ser         <= byte_data;
                ADDR_W'(ADDR_TCM):      trigger_channel_mask <= byte_data;
                ADDR_W'(ADDR_INSTR):    instruction          <= byte_data;
                ADDR_W'(ADDR_MODE):     mode                 <= byte_data;
                ADDR_W'(ADDR_SELECT):   select_reg           <= byte_data[2:0];
                default:                load_cnt_ser         <= load_cnt_ser;
            endcase
        end
    end

`ifdef SPI_SERIAL_OUT_EN
    logic [7:0] rd_value;
    logic [7:0] out_cap;

    // Readback mux for the currently addressed register; unmapped reads as 0.
    always_comb begin
        rd_value = 8'd0;
        case (ptr)
            ADDR_W'(ADDR_LOAD_CNT): rd_value = load_cnt_ser;
            ADDR_W'(ADDR_TCM):      rd_value = trigger_channel_mask;
            ADDR_W'(ADDR_INSTR):    rd_value = instruction;
            ADDR_W'(ADDR_MODE):     rd_value = mode;
            ADDR_W'(ADDR_SELECT):   rd_value = {5'd0, select_reg};
            default:                rd_value = 8'd0;
        endcase
    end

    // Falling-edge launcher: capture at the byte boundary, then present one bit per edge.
    always_ff @(negedge sclk or posedge rst) begin
        if (rst) begin
            out_cap    <= 8'd0;
            serial_out <= 1'b0;
        end else if (phase == PH_DATA) begin
            if (bit_cnt == 3'd0) begin
                out_cap    <= rd_value;
                serial_out <= rd_value[7];
            end else begin
                out_cap    <= out_cap;
                serial_out <= out_cap[3'd7 - bit_cnt];
            end
        end else begin
            out_cap    <= 8'd0;
            serial_out <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_spi_reg_bank.sv
// Self-checking bench for spi_reg_bank: directed vector table, hand-written
// reset corner cases, and randomized byte streams against a byte-level model.
// With SPI_SERIAL_OUT_EN defined, serial_out is also checked on every byte.
module tb_spi_reg_bank;

    logic       sclk;
    logic       rst;
    logic       serial_in;
    logic [7:0] load_cnt_ser;
    logic [7:0] trigger_channel_mask;
    logic [7:0] instruction;
    logic [7:0] mode;
    logic [2:0] select_reg;
`ifdef SPI_SERIAL_OUT_EN
    logic       serial_out;
`endif

    spi_reg_bank dut (
        .sclk                 (sclk),
        .rst                  (rst),
        .serial_in            (serial_in),
        .load_cnt_ser         (load_cnt_ser),
        .trigger_channel_mask (trigger_channel_mask),
        .instruction          (instruction),
        .mode                 (mode),
        .select_reg           (select_reg)
`ifdef SPI_SERIAL_OUT_EN
        ,
        .serial_out           (serial_out)
`endif
    );

    int n_cmp = 0;
    int n_err = 0;

    // Byte-level reference model: five registers, pointer, address-phase flag.
    logic [7:0] m_reg [5];
    int         m_ptr;
    bit         m_addr_phase;

    typedef struct {
        logic [47:0] bytes;   // up to six bytes, first byte in bits [47:40]
        int          n;
        logic [7:0]  e_lcs;
        logic [7:0]  e_tcm;
        logic [7:0]  e_ins;
        logic [7:0]  e_mode;
        logic [2:0]  e_sel;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                                 input logic [7:0] e2, input logic [7:0] e3, input logic [2:0] e4);
        check({tag, " load_cnt_ser"}, load_cnt_ser, e0);
        check({tag, " trigger_channel_mask"}, trigger_channel_mask, e1);
        check({tag, " instruction"}, instruction, e2);
        check({tag, " mode"}, mode, e3);
        check({tag, " select_reg"}, {5'd0, select_reg}, {5'd0, e4});
    endtask

    task automatic check_model(input string tag);
        check_outputs(tag, m_reg[0], m_reg[1], m_reg[2], m_reg[3], m_reg[4][2:0]);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 5; i++) m_reg[i] = 8'h00;
        m_ptr        = 0;
        m_addr_phase = 1'b1;
    endtask

    task automatic model_byte(input logic [7:0] b);
        if (m_addr_phase) begin
            m_ptr        = int'(b);
            m_addr_phase = 1'b0;
        end else begin
            if (m_ptr < 5) m_reg[m_ptr] = (m_ptr == 4) ? {5'd0, b[2:0]} : b;
            m_ptr = (m_ptr + 1) % 256;
        end
    endtask

    task automatic pulse();
        #5 sclk = 1'b1;
        #5 sclk = 1'b0;
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            serial_in = b[7-i];
            pulse();
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
`ifdef SPI_SERIAL_OUT_EN
        logic [7:0] so_exp;
        logic [7:0] so_got;
        so_exp = (!m_addr_phase && m_ptr < 5) ? m_reg[m_ptr] : 8'h00;
        for (int i = 0; i < 8; i++) begin
            so_got[7-i] = serial_out;
            serial_in   = b[7-i];
            pulse();
        end
        check("serial_out readback", so_got, so_exp);
`else
        send_bits(b, 8);
`endif
        model_byte(b);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #3 rst = 1'b0;
        #2;
        model_reset();
    endtask

    initial begin
        sclk      = 1'b0;
        rst       = 1'b0;
        serial_in = 1'b0;
        model_reset();

        vecs[0] = '{48'h00_00_00_00_00_00, 0, 8'h00, 8'h00, 8'h00, 8'h00, 3'h0};
        vecs[1] = '{48'h01_10_02_01_00_00, 4, 8'h00, 8'h10, 8'h02, 8'h01, 3'h0};
        vecs[2] = '{48'h00_A5_3C_5A_81_FF, 6, 8'hA5, 8'h3C, 8'h5A, 8'h81, 3'h7};
        vecs[3] = '{48'h04_06_77_00_00_00, 3, 8'h00, 8'h00, 8'h00, 8'h00, 3'h6};
        vecs[4] = '{48'h03_42_00_00_00_00, 2, 8'h00, 8'h00, 8'h00, 8'h42, 3'h0};
        vecs[5] = '{48'hFE_11_22_33_00_00, 4, 8'h33, 8'h00, 8'h00, 8'h00, 3'h0};

        // Directed vectors, each starting from reset.
        for (int v = 0; v < 6; v++) begin
            do_reset();
            for (int k = 0; k < vecs[v].n; k++) send_byte(vecs[v].bytes[47-8*k -: 8]);
            check_outputs($sformatf("vec%0d", v), vecs[v].e_lcs, vecs[v].e_tcm,
                          vecs[v].e_ins, vecs[v].e_mode, vecs[v].e_sel);
        end

        // Reset mid-byte discards the partial byte and restarts at the address phase.
        do_reset();
        send_byte(8'h02);
        send_bits(8'hFF, 5);
        do_reset();
        check_outputs("midreset", 8'h00, 8'h00, 8'h00, 8'h00, 3'h0);
        send_byte(8'h03);
        send_byte(8'h42);
        check_outputs("midreset_after", 8'h00, 8'h00, 8'h00, 8'h42, 3'h0);

        // Clock edges while rst is held high have no effect.
        do_reset();
        send_byte(8'h00);
        send_byte(8'h5C);
        rst = 1'b1;
        send_bits(8'hFF, 8);
        send_bits(8'h0B, 7);
        rst = 1'b0;
        #2;
        model_reset();
        check_outputs("held_reset", 8'h00, 8'h00, 8'h00, 8'h00, 3'h0);
        send_byte(8'h01);
        send_byte(8'hAB);
        check_outputs("held_reset_after", 8'h00, 8'hAB, 8'h00, 8'h00, 3'h0);

`ifdef SPI_SERIAL_OUT_EN
        // Pointer wraps through 255 back to 0; the byte at 0 replays its earlier value.
        do_reset();
        send_byte(8'h00);
        send_byte(8'hA5);
        for (int k = 0; k < 255; k++) send_byte(8'h00);
        send_byte(8'h3C);
        check_model("so_wrap");
`endif

        // Randomized transactions with idle gaps, compared after every byte.
        for (int t = 0; t < 25; t++) begin
            int         n;
            logic [7:0] a;
            do_reset();
            a = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 7)) : 8'($urandom_range(248, 255));
            n = $urandom_range(1, 10);
            send_byte(a);
            for (int k = 0; k < n; k++) begin
                #($urandom_range(0, 30));
                send_byte(8'($urandom));
                check_model($sformatf("rand%0d.%0d", t, k));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
